// File: rtl/controlador_sequencia.sv
// controlador_sequencia: run controller for the 4-bit serial sequence
// identifier. Holds the reference pattern, clears and fills the identifier
// window, then counts matches until a programmed target (0 = run forever).
module controlador_sequencia #(
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_ref,
  input  logic [W_CNT-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             id_in,
  output logic [3:0]       id_refe,
  output logic             id_clr,
  input  logic             id_flag,
  output logic             match,
  output logic [W_CNT-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [W_CNT-1:0] CNT_ZERO = {W_CNT{1'b0}};
  localparam logic [W_CNT-1:0] CNT_ONE  = {{(W_CNT-1){1'b0}}, 1'b1};
  localparam logic [W_CNT-1:0] CNT_MAX  = {W_CNT{1'b1}};

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    logic [W_CNT-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  state_e           state_q;
  logic [3:0]       ref_q;
  logic [W_CNT-1:0] tgt_q;
  logic [W_CNT-1:0] match_cnt_q;
  logic [1:0]       fill_q;
  logic             cfg_ready_q;
  logic             bit_ready_q;
  logic             id_clr_q;
  logic             match_q;
  logic             busy_q;
  logic             done_q;

  logic [W_CNT-1:0] match_cnt_d;
  logic             tgt_hit_s;
  logic             cfg_acc_s;

  assign cfg_acc_s = cfg_valid & cfg_ready_q;

  // Next match count and whether it would reach a non-zero target.
  always_comb begin
    match_cnt_d = sat_inc(match_cnt_q);
    tgt_hit_s   = (tgt_q != CNT_ZERO) && (match_cnt_d == tgt_q);
  end

  // Run FSM with all control outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ref_q       <= 4'b0000;
      tgt_q       <= CNT_ZERO;
      match_cnt_q <= CNT_ZERO;
      fill_q      <= 2'd0;
      cfg_ready_q <= 1'b1;
      bit_ready_q <= 1'b0;
      id_clr_q    <= 1'b0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      match_q <= 1'b0;
      // Config acceptance is independent of abort/start: it completes
      // whenever cfg_ready is high, and a same-edge start uses the new values.
      if (cfg_acc_s) begin
        ref_q <= cfg_ref;
        tgt_q <= cfg_count;
      end
      if (abort) begin
        state_q     <= S_IDLE;
        cfg_ready_q <= 1'b1;
        bit_ready_q <= 1'b0;
        id_clr_q    <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q     <= S_CLEAR;
              match_cnt_q <= CNT_ZERO;
              cfg_ready_q <= 1'b0;
              id_clr_q    <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end else begin
              state_q <= state_q;
            end
          end
          S_CLEAR: begin
            state_q     <= S_FILL;
            fill_q      <= 2'd0;
            id_clr_q    <= 1'b0;
            bit_ready_q <= 1'b1;
          end
          S_FILL: begin
            // Window still holds cleared zeros, so id_flag is not trusted yet.
            fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd3) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_FILL;
            end
          end
          S_RUN: begin
            if (id_flag) begin
              match_q     <= 1'b1;
              match_cnt_q <= match_cnt_d;
              if (tgt_hit_s) begin
                state_q     <= S_DONE;
                bit_ready_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                cfg_ready_q <= 1'b1;
              end else begin
                state_q <= S_RUN;
              end
            end else begin
              state_q <= S_RUN;
            end
          end
          default: begin
            state_q     <= S_IDLE;
            cfg_ready_q <= 1'b1;
            bit_ready_q <= 1'b0;
            id_clr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign bit_ready = bit_ready_q;
  assign id_in     = bit_ready_q & bit_in;
  assign id_refe   = ref_q;
  assign id_clr    = id_clr_q;
  assign match     = match_q;
  assign match_cnt = match_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_controlador_sequencia.sv
// Bench for controlador_sequencia: a behavioural 4-bit identifier drives
// id_flag, directed runs push expected match pulses into a scoreboard and a
// monitor pops and checks them whenever match is high.
module tb_controlador_sequencia;

  localparam int W_CNT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_ref;
  logic [W_CNT-1:0] cfg_count;
  logic             start;
  logic             abort;
  logic             bit_in;
  logic             bit_ready;
  logic             id_in;
  logic [3:0]       id_refe;
  logic             id_clr;
  logic             id_flag;
  logic             match;
  logic [W_CNT-1:0] match_cnt;
  logic             busy;
  logic             done;

  controlador_sequencia #(.W_CNT(W_CNT)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ref(cfg_ref), .cfg_count(cfg_count),
    .start(start), .abort(abort),
    .bit_in(bit_in), .bit_ready(bit_ready),
    .id_in(id_in), .id_refe(id_refe), .id_clr(id_clr), .id_flag(id_flag),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n (and until edge n+1) cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Identifier model: newest bit enters at [3], oldest sits at [0].
  logic [3:0] win_q;
  always @(posedge clk) begin
    if (reset || id_clr) win_q <= 4'b0000;
    else                 win_q <= {id_in, win_q[3:1]};
  end
  assign id_flag = (win_q == id_refe);

  // Bit source: presents the next stream bit in each cycle bit_ready is high.
  bit bits_q[$];
  always @(posedge clk) begin
    #1;
    if (bit_ready && bits_q.size() > 0) bit_in = bits_q.pop_front();
    else                                bit_in = 1'b0;
  end

  typedef struct {
    int cyc;
    int cnt;
    int dn;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every match pulse must correspond to the next expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && match === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_match: got pulse at cyc %0d cnt %0d, expected none", cyc, match_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("match_cycle", cyc, e.cyc);
        chk("match_cnt_at_pulse", int'(match_cnt), e.cnt);
        chk("done_at_pulse", int'(done), e.dn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [3:0] r, input logic [W_CNT-1:0] c);
    cfg_valid = 1'b1;
    cfg_ref   = r;
    cfg_count = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic push_exp(input int c, input int n, input int d);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    e.dn  = d;
    sb_q.push_back(e);
  endtask

  int e0;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_ref = 4'b0000; cfg_count = '0;
    start = 1'b0; abort = 1'b0; bit_in = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Idle state after reset
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_id_refe", int'(id_refe), 0);
    chk("rst_bit_ready", int'(bit_ready), 0);
    tick();

    // Overlapping matches: ref time order 1,1,0,1, target 2
    do_cfg(4'b1011, 8'd2);
    bits_q = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    e0 = cyc + 1;
    push_exp(e0 + 6, 1, 0);
    push_exp(e0 + 9, 2, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("ovl_clear_busy", int'(busy), 1);
    chk("ovl_clear_idclr", int'(id_clr), 1);
    chk("ovl_clear_cfg_ready", int'(cfg_ready), 0);
    for (int i = 0; i < 9; i++) tick();
    chk("ovl_done", int'(done), 1);
    chk("ovl_busy_at_done", int'(busy), 0);
    chk("ovl_cnt", int'(match_cnt), 2);
    tick();
    chk("ovl_bit_ready_after", int'(bit_ready), 0);
    chk("ovl_done_hold", int'(done), 1);
    chk("ovl_cnt_hold", int'(match_cnt), 2);

    // Config and start on the same edge from DONE: ref time order 1,0,1,0
    bits_q = {1'b1, 1'b0, 1'b1, 1'b0};
    e0 = cyc + 1;
    push_exp(e0 + 6, 1, 1);
    cfg_valid = 1'b1; cfg_ref = 4'b0101; cfg_count = 8'd1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cs_cnt_cleared", int'(match_cnt), 0);
    chk("cs_id_refe", int'(id_refe), 5);
    for (int i = 0; i < 8; i++) tick();
    chk("cs_done", int'(done), 1);

    // Leading-zero guard: ref time order 1,0,0,0, target 1
    do_cfg(4'b0001, 8'd1);
    bits_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e0 = cyc + 1;
    push_exp(e0 + 10, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    chk("lz_done", int'(done), 1);
    chk("lz_cnt", int'(match_cnt), 1);

    // Free-running: target 0, ref all ones, 20 ones -> 17 matches
    do_cfg(4'b1111, 8'd0);
    bits_q = {};
    for (int i = 0; i < 20; i++) bits_q.push_back(1'b1);
    e0 = cyc + 1;
    for (int i = 0; i < 17; i++) push_exp(e0 + 6 + i, i + 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      chk("fr_busy", int'(busy), 1);
      chk("fr_done", int'(done), 0);
      if (i == 8) begin
        cfg_valid = 1'b1; cfg_ref = 4'b0000; cfg_count = 8'd5;
        chk("fr_cfg_ready_run", int'(cfg_ready), 0);
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0;
    chk("fr_ref_unchanged", int'(id_refe), 15);
    chk("fr_cnt", int'(match_cnt), 17);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("fr_abort_busy", int'(busy), 0);
    chk("fr_abort_cnt_hold", int'(match_cnt), 17);

    // Abort during FILL, with start on the same edge
    do_cfg(4'b1011, 8'd0);
    bits_q = {1'b1, 1'b1, 1'b0, 1'b1};
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("ab1_in_fill", int'(bit_ready), 1);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("ab1_busy", int'(busy), 0);
    chk("ab1_cfg_ready", int'(cfg_ready), 1);
    chk("ab1_bit_ready", int'(bit_ready), 0);
    chk("ab1_cnt", int'(match_cnt), 0);
    tick(); tick();
    chk("ab1_stay_idle", int'(busy), 0);

    // Abort in RUN after one match, with start on the same edge
    bits_q = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e0 = cyc + 1;
    push_exp(e0 + 6, 1, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("ab2_running", int'(busy), 1);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("ab2_busy", int'(busy), 0);
    chk("ab2_cnt_hold", int'(match_cnt), 1);
    chk("ab2_done", int'(done), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("ab2_stay_idle", int'(busy), 0);
    chk("ab2_cnt_final", int'(match_cnt), 1);

    chk("missing_matches", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
